// File: rtl/sdp_rdma_rd_arb.sv
// SDP RDMA read arbiter: round-robin merge of three read requesters onto one MCIF
// read port, with an in-order context FIFO that routes response beats back.
module sdp_rdma_rd_arb #(
  parameter int CTX_DEPTH = 8
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic [2:0]    rdma_req_valid,
  output logic [2:0]    rdma_req_ready,
  input  logic [140:0]  rdma_req_pd,
  output logic [2:0]    rdma_rsp_valid,
  input  logic [2:0]    rdma_rsp_ready,
  output logic [64:0]   rdma_rsp_pd,
  output logic          mcif_rd_req_valid,
  input  logic          mcif_rd_req_ready,
  output logic [46:0]   mcif_rd_req_pd,
  input  logic          mcif_rd_rsp_valid,
  output logic          mcif_rd_rsp_ready,
  input  logic [64:0]   mcif_rd_rsp_pd,
  output logic [5:0]    outstanding_cnt,
  output logic          arb_idle,
  output logic          rsp_orphan_err
);

  localparam int          AW      = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
  localparam logic [5:0]  DEPTH_C = 6'(CTX_DEPTH);

  typedef struct packed {
    logic [1:0]  id;
    logic [14:0] beats;
  } ctx_t;

  // Requester index 'off' places after 'base' in the 0,1,2 ring.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  logic [1:0]     r_ptr;
  logic           r_out_valid;
  logic [46:0]    r_out_pd;
  ctx_t           r_ctx_mem [CTX_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [5:0]     r_cnt;
  logic [14:0]    r_beat;
  logic           r_orphan;

  logic           w_can_grant;
  logic           w_found;
  logic [1:0]     w_gnt_idx;
  logic           w_push;
  logic [46:0]    w_gnt_pd;
  ctx_t           w_head;
  logic           w_ctx_ne;
  logic           w_head_rdy;
  logic [2:0]     w_rsp_valid;
  logic           w_beat_acc;
  logic           w_pop;

  // Full context FIFO blocks a grant even when the last beat pops this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_found   = 1'b0;
    w_gnt_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && rdma_req_valid[rr_idx(r_ptr, 2'(k))]) begin
        w_found   = 1'b1;
        w_gnt_idx = rr_idx(r_ptr, 2'(k));
      end
    end
    w_can_grant = (!r_out_valid || mcif_rd_req_ready) && (r_cnt < DEPTH_C);
    w_push      = w_found && w_can_grant;
    w_gnt_pd    = rdma_req_pd[47*w_gnt_idx +: 47];
  end

  assign rdma_req_ready = w_push ? (3'b001 << w_gnt_idx) : 3'b000;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_ptr       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_pd    <= '0;
    end else begin
      if (w_push) begin
        r_ptr       <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
        r_out_valid <= 1'b1;
        r_out_pd    <= w_gnt_pd;
      end else if (mcif_rd_req_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mcif_rd_req_valid = r_out_valid;
  assign mcif_rd_req_pd    = r_out_pd;

  // NOTE: context storage has no reset; emptiness is tracked solely by pointers and count.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_ctx_mem[r_wr_ptr] <= '{id: w_gnt_idx, beats: w_gnt_pd[46:32]};
  end

  assign w_head   = r_ctx_mem[r_rd_ptr];
  assign w_ctx_ne = (r_cnt != 6'd0);

  always_comb begin
    w_rsp_valid = 3'b000;
    w_head_rdy  = 1'b0;
    case (w_head.id)
      2'd0, 2'd1, 2'd2: begin
        w_rsp_valid[w_head.id] = mcif_rd_rsp_valid & w_ctx_ne;
        w_head_rdy             = rdma_rsp_ready[w_head.id] & w_ctx_ne;
      end
      default: ;
    endcase
  end

  assign rdma_rsp_valid    = w_rsp_valid;
  assign rdma_rsp_pd       = mcif_rd_rsp_pd;
  assign mcif_rd_rsp_ready = w_head_rdy;
  assign w_beat_acc        = mcif_rd_rsp_valid & w_head_rdy;
  assign w_pop             = w_beat_acc & (r_beat == w_head.beats);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 6'd0;
      r_beat   <= 15'd0;
      r_orphan <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 6'd1;
        2'b01:   r_cnt <= r_cnt - 6'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_pop)           r_beat <= 15'd0;
      else if (w_beat_acc) r_beat <= r_beat + 15'd1;
      if (mcif_rd_rsp_valid && !w_ctx_ne) r_orphan <= 1'b1;
    end
  end

  assign outstanding_cnt = r_cnt;
  assign arb_idle        = !r_out_valid && !w_ctx_ne;
  assign rsp_orphan_err  = r_orphan;

endmodule

// File: tb/tb_sdp_rdma_rd_arb.sv
// Directed bench for sdp_rdma_rd_arb: a per-cycle arbitration vector table plus
// hand-written response, backpressure, full-FIFO, orphan and mid-run reset sequences.
module tb_sdp_rdma_rd_arb;

  logic          clk;
  logic          rst_n;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [140:0]  req_pd;
  logic [2:0]    rsp_valid;
  logic [2:0]    rsp_ready;
  logic [64:0]   rsp_pd;
  logic          mreq_valid;
  logic          mreq_ready;
  logic [46:0]   mreq_pd;
  logic          mrsp_valid;
  logic          mrsp_ready;
  logic [64:0]   mrsp_pd;
  logic [5:0]    cnt;
  logic          idle;
  logic          orphan;

  int checks   = 0;
  int failures = 0;

  sdp_rdma_rd_arb #(.CTX_DEPTH(8)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .rdma_req_valid    (req_valid),
    .rdma_req_ready    (req_ready),
    .rdma_req_pd       (req_pd),
    .rdma_rsp_valid    (rsp_valid),
    .rdma_rsp_ready    (rsp_ready),
    .rdma_rsp_pd       (rsp_pd),
    .mcif_rd_req_valid (mreq_valid),
    .mcif_rd_req_ready (mreq_ready),
    .mcif_rd_req_pd    (mreq_pd),
    .mcif_rd_rsp_valid (mrsp_valid),
    .mcif_rd_rsp_ready (mrsp_ready),
    .mcif_rd_rsp_pd    (mrsp_pd),
    .outstanding_cnt   (cnt),
    .arb_idle          (idle),
    .rsp_orphan_err    (orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] req_valid;
    logic       out_ready;
    logic [2:0] exp_req_ready;
    logic       exp_out_valid;
    logic [1:0] exp_out_id;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [14:0] size);
    req_pd[47*i +: 47] = {size, addr};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = 3'b000;
    rsp_ready  = 3'b000;
    mreq_ready = 1'b0;
    mrsp_valid = 1'b0;
    mrsp_pd    = '0;
    for (int i = 0; i < 3; i++) set_req(i, 32'h1000_0000 + 32'(i), 15'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    mrsp_pd = 65'h1_CAFE_F00D_1234_5678;
    #1;
    check({tag, "_mreq_valid"}, 128'(mreq_valid), 128'd0);
    check({tag, "_cnt"},        128'(cnt),        128'd0);
    check({tag, "_idle"},       128'(idle),       128'd1);
    check({tag, "_req_ready"},  128'(req_ready),  128'd0);
    check({tag, "_rsp_valid"},  128'(rsp_valid),  128'd0);
    check({tag, "_mrsp_ready"}, 128'(mrsp_ready), 128'd0);
    check({tag, "_orphan"},     128'(orphan),     128'd0);
    check({tag, "_rsp_pd"},     128'(rsp_pd),     128'h1_CAFE_F00D_1234_5678);
    mrsp_pd = '0;
  endtask

  initial begin
    int grants;
    rst_n = 1'b0;
    req_pd = '0;
    do_reset();
    rst_n = 1'b0;
    check_reset_outs("rst_in");
    rst_n = 1'b1;

    // Per cycle: drive inputs, check pre-edge outputs, then let the edge happen.
    vecs[0]  = '{3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 6'd0};
    vecs[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 6'd1};
    vecs[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 6'd2};
    vecs[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 6'd3};
    vecs[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 6'd4};
    vecs[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 6'd5};
    vecs[6]  = '{3'b000, 1'b0, 3'b000, 1'b1, 2'd2, 6'd6};
    vecs[7]  = '{3'b010, 1'b0, 3'b000, 1'b1, 2'd2, 6'd6};
    vecs[8]  = '{3'b110, 1'b1, 3'b010, 1'b1, 2'd2, 6'd6};
    vecs[9]  = '{3'b101, 1'b1, 3'b100, 1'b1, 2'd1, 6'd7};
    vecs[10] = '{3'b111, 1'b1, 3'b000, 1'b1, 2'd2, 6'd8};
    vecs[11] = '{3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 6'd8};

    do_reset();
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      req_valid  = vecs[v].req_valid;
      mreq_ready = vecs[v].out_ready;
      #1;
      check($sformatf("vec%0d_req_ready", v),  128'(req_ready),  128'(vecs[v].exp_req_ready));
      check($sformatf("vec%0d_mreq_valid", v), 128'(mreq_valid), 128'(vecs[v].exp_out_valid));
      check($sformatf("vec%0d_cnt", v),        128'(cnt),        128'(vecs[v].exp_cnt));
      if (vecs[v].exp_out_valid)
        check($sformatf("vec%0d_mreq_addr", v), 128'(mreq_pd[31:0]),
              128'(32'h1000_0000 + 32'(vecs[v].exp_out_id)));
    end

    // Size-3 request from 0 then size-0 request from 2, then their five beats.
    do_reset();
    @(negedge clk);
    set_req(0, 32'hA000_0040, 15'd3);
    set_req(2, 32'hB000_0080, 15'd0);
    req_valid = 3'b001; mreq_ready = 1'b1;
    #1 check("rsp_seq_gnt0", 128'(req_ready), 128'b001);
    @(negedge clk);
    req_valid = 3'b100;
    #1 check("rsp_seq_gnt2", 128'(req_ready), 128'b100);
    check("rsp_seq_pd0", 128'(mreq_pd), 128'({15'd3, 32'hA000_0040}));
    @(negedge clk);
    req_valid = 3'b000;
    #1 check("rsp_seq_pd2", 128'(mreq_pd), 128'({15'd0, 32'hB000_0080}));
    check("rsp_seq_cnt2", 128'(cnt), 128'd2);
    @(negedge clk);
    mrsp_valid = 1'b1; mrsp_pd = 65'h1_0000_0000_0000_00D0; rsp_ready = 3'b000;
    #1 check("rsp_bp_valid", 128'(rsp_valid), 128'b001);
    check("rsp_bp_mready", 128'(mrsp_ready), 128'd0);
    check("rsp_bp_idle", 128'(idle), 128'd0);
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      rsp_ready = 3'b111;
      mrsp_pd   = {1'b1, 64'hD0 + 64'(b)};
      #1;
      check($sformatf("beat%0d_valid", b), 128'(rsp_valid), (b < 4) ? 128'b001 : 128'b100);
      check($sformatf("beat%0d_mready", b), 128'(mrsp_ready), 128'd1);
      check($sformatf("beat%0d_pd", b), 128'(rsp_pd), 128'({1'b1, 64'hD0 + 64'(b)}));
      if (b == 4) check("beat4_cnt", 128'(cnt), 128'd1);
    end
    @(negedge clk);
    mrsp_valid = 1'b0;
    #1 check("rsp_done_cnt", 128'(cnt), 128'd0);
    check("rsp_done_idle", 128'(idle), 128'd1);
    check("rsp_done_orphan", 128'(orphan), 128'd0);

    // Response with no outstanding context.
    @(negedge clk);
    mrsp_valid = 1'b1;
    #1 check("orphan_mready", 128'(mrsp_ready), 128'd0);
    check("orphan_rsp_valid", 128'(rsp_valid), 128'd0);
    @(negedge clk);
    mrsp_valid = 1'b0;
    #1 check("orphan_set", 128'(orphan), 128'd1);
    repeat (3) @(negedge clk);
    #1 check("orphan_sticky", 128'(orphan), 128'd1);

    // Reset with five outstanding and a pending output request; no replay after.
    do_reset();
    #1 check("orphan_cleared", 128'(orphan), 128'd0);
    @(negedge clk);
    req_valid = 3'b001; mreq_ready = 1'b1;
    repeat (5) @(negedge clk);
    req_valid = 3'b000; mreq_ready = 1'b0;
    #1 check("midrst_pre_cnt", 128'(cnt), 128'd5);
    check("midrst_pre_valid", 128'(mreq_valid), 128'd1);
    #1 rst_n = 1'b0;
    #1 check("midrst_async_valid", 128'(mreq_valid), 128'd0);
    check("midrst_async_cnt", 128'(cnt), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outs("midrst_rel");
    mreq_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("midrst_noreplay_valid", 128'(mreq_valid), 128'd0);
    check("midrst_noreplay_cnt", 128'(cnt), 128'd0);

    // Requester 1 streams with no responses: exactly CTX_DEPTH grants.
    do_reset();
    grants = 0;
    @(negedge clk);
    req_valid = 3'b010; mreq_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) @(negedge clk);
      #1 if (req_ready[1]) grants++;
    end
    check("stream_grants", 128'(grants), 128'd8);
    check("stream_cnt", 128'(cnt), 128'd8);
    check("stream_req_ready", 128'(req_ready), 128'd0);
    check("stream_out_drained", 128'(mreq_valid), 128'd0);

    // Full FIFO while the last beat pops: grant only on the following cycle.
    do_reset();
    @(negedge clk);
    req_valid = 3'b001; mreq_ready = 1'b1;
    repeat (12) @(negedge clk);
    rsp_ready = 3'b111; mrsp_valid = 1'b1;
    #1 check("fullpop_no_gnt", 128'(req_ready), 128'd0);
    check("fullpop_cnt", 128'(cnt), 128'd8);
    check("fullpop_rsp_valid", 128'(rsp_valid), 128'b001);
    @(negedge clk);
    mrsp_valid = 1'b0;
    #1 check("fullpop_next_gnt", 128'(req_ready), 128'b001);
    check("fullpop_next_cnt", 128'(cnt), 128'd7);
    @(negedge clk);
    #1 check("fullpop_refill_cnt", 128'(cnt), 128'd8);
    check("fullpop_refill_gnt", 128'(req_ready), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
